score_bcd: RTL and testbench
============================

SCORE_BCD -- requirements
Module: score_bcd

Interface
REQ-001 Parameter: LINES_PER_LEVEL, default 10, lines cleared per level step (legal 1..15; used only when SCORE_LEVEL_EN is defined).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 score_clr  input  1  synchronous new-game clear.
REQ-005 clear_valid  input  1  line-clear event request.
REQ-006 clear_lines  input  3  number of lines cleared in the event (1..4 legal).
REQ-007 ready  output  1  high when a clear_valid request will be accepted.
REQ-008 digit0..digit3  output  4 each  registered BCD score digits, ones to thousands, one per seven-segment decoder in_4 input.
REQ-009 level  output  4  registered BCD level digit, 0..9.

Function
REQ-010 A request SHALL be accepted on an edge where clear_valid=1 and ready=1; clear_valid with ready=0 SHALL be ignored, not queued.
REQ-011 Points per request SHALL be: 1 line=1, 2=3, 3=5, 4=8; clear_lines 0 or 5..7 SHALL add 0 and SHALL count as 0 lines.
REQ-012 FSM states SHALL be IDLE and ADD, with ready=1 only in IDLE.
REQ-013 IDLE->ADD on acceptance: latch points, digit index=0, carry=0, and copy the display digits into a working register.
REQ-014 In ADD, each edge SHALL add one working digit: edge k (k=1..4 after acceptance) updates digit k-1 with sum = digit + (points if k=1 else 0) + carry; if sum>9, the digit becomes sum-10 and carry=1.
REQ-015 On the 4th ADD edge the FSM SHALL return to IDLE and copy the working register to digit0..digit3 in the same edge; ready SHALL rise after that edge (busy for exactly 4 cycles).
REQ-016 If the thousands digit produces a carry, the display SHALL saturate to 9999 and SHALL stay at 9999 for all later adds.
REQ-017 digit0..digit3 SHALL change only on the final ADD edge or on clear/reset, never mid-add.
REQ-018 score_clr=1 SHALL have priority over everything: next edge zeroes the score, level and line counter, forces IDLE, aborts any add in progress, and discards a simultaneous clear_valid.
REQ-019 Outputs SHALL hold their values indefinitely while idle.

Reset
REQ-020 rst=1 SHALL immediately force IDLE, ready=1, digit0..digit3=0, level=0, line counter=0, working register=0, carry=0.
REQ-021 rst asserted mid-ADD SHALL abandon the add; no partial result SHALL become visible.

Configuration
REQ-022 Macro SCORE_LEVEL_EN: when defined, a 4-bit line counter SHALL add the accepted line count on the final ADD edge.
REQ-023 Level stepping: when the line counter reaches or exceeds LINES_PER_LEVEL, level SHALL increment by 1 (saturating at 9) and the counter SHALL reduce by LINES_PER_LEVEL.
REQ-024 Without SCORE_LEVEL_EN, level SHALL be constant 0 and no line counter SHALL be synthesized; score behaviour SHALL be identical.

Verification
REQ-025 Reset, then one request with clear_lines=4 -> ready low for 4 cycles; digits show 0008 after the 4th edge; ready=1.
REQ-026 Preload 0099, then clear_lines=1 -> 0100 after 4 cycles; the display holds 0099 during ADD.
REQ-027 Preload 9995, then clear_lines=4 -> 9999; a further clear_lines=2 request -> still 9999.
REQ-028 Assert clear_valid during ADD -> the request is ignored; the final score reflects only the first request.
REQ-029 score_clr together with clear_valid in IDLE, and again mid-ADD -> 0000, level 0, ready=1 after one edge; rst pulse mid-ADD -> immediate 0000.
REQ-030 With SCORE_LEVEL_EN and LINES_PER_LEVEL=10: three clear_lines=4 requests -> level 1, line counter 2; without the macro -> level stays 0, score 0024.

Source files
------------

// File: rtl/score_bcd_if.sv
// rtl/score_bcd_if.sv - request/display bundle between a game controller and score_bcd
//
// Signals:
//   score_clr    controller -> score   synchronous new-game clear
//   clear_valid  controller -> score   line-clear event request
//   clear_lines  controller -> score   lines cleared in the event (1..4)
//   ready        score -> controller   high while a request would be accepted
//   digit0..3    score -> display      BCD score digits, ones to thousands
//   level        score -> display      BCD level digit
interface score_bcd_if;
    logic       score_clr;
    logic       clear_valid;
    logic [2:0] clear_lines;
    logic       ready;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] level;

    modport master (
        output score_clr, clear_valid, clear_lines,
        input  ready, digit0, digit1, digit2, digit3, level
    );

    modport slave (
        input  score_clr, clear_valid, clear_lines,
        output ready, digit0, digit1, digit2, digit3, level
    );
endinterface

// File: rtl/score_bcd.sv
// rtl/score_bcd.sv - four-digit BCD score accumulator with optional level tracking
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  score_bcd_if.slave (score_clr, clear_valid, clear_lines, ready,
//        digit0..digit3, level)
//
// Parameter LINES_PER_LEVEL (1..15): lines per level step.
// Optional feature macro SCORE_LEVEL_EN: adds the line counter and level
// digit; otherwise level is tied to 0.
//
// An accepted request is added one BCD digit per cycle into a working copy
// of the display; the display is only replaced on the fourth add cycle so
// that partial sums are never visible.
module score_bcd #(
    parameter int LINES_PER_LEVEL = 10
) (
    input  logic        clk,
    input  logic        rst,
    score_bcd_if.slave  bus
);

    typedef enum logic {IDLE, ADD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic [3:0]  pts_q, pts_d;
    logic [15:0] work_q, work_d;
    logic [15:0] disp_q, disp_d;

    logic        accept;
    logic        final_edge;
    logic [3:0]  cur_digit;
    logic [3:0]  addend;
    logic [4:0]  sum;
    logic [3:0]  new_digit;
    logic        new_carry;

    generate
        if (LINES_PER_LEVEL < 1 || LINES_PER_LEVEL > 15) begin : g_bad_lpl
            $error("LINES_PER_LEVEL must be in 1..15");
        end
    endgenerate

    function automatic logic [3:0] points_of(input logic [2:0] lines);
        case (lines)
            3'd1:    return 4'd1;
            3'd2:    return 4'd3;
            3'd3:    return 4'd5;
            3'd4:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    assign accept     = (state_q == IDLE) && bus.clear_valid;
    assign final_edge = (state_q == ADD) && (idx_q == 2'd3);

    // One BCD digit adder shared across the four add cycles.
    always_comb begin
        cur_digit = 4'd0;
        case (idx_q)
            2'd0: cur_digit = work_q[3:0];
            2'd1: cur_digit = work_q[7:4];
            2'd2: cur_digit = work_q[11:8];
            2'd3: cur_digit = work_q[15:12];
            default: cur_digit = 4'd0;
        endcase
        addend = (idx_q == 2'd0) ? pts_q : 4'd0;
        sum    = {1'b0, cur_digit} + {1'b0, addend} + {4'd0, carry_q};
        if (sum > 5'd9) begin
            new_digit = 4'(sum - 5'd10);
            new_carry = 1'b1;
        end else begin
            new_digit = sum[3:0];
            new_carry = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        pts_d   = pts_q;
        work_d  = work_q;
        disp_d  = disp_q;
        if (bus.score_clr) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            carry_d = 1'b0;
            pts_d   = 4'd0;
            work_d  = 16'd0;
            disp_d  = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = ADD;
                        idx_d   = 2'd0;
                        carry_d = 1'b0;
                        pts_d   = points_of(bus.clear_lines);
                        work_d  = disp_q;
                    end
                end
                ADD: begin
                    case (idx_q)
                        2'd0: work_d[3:0]   = new_digit;
                        2'd1: work_d[7:4]   = new_digit;
                        2'd2: work_d[11:8]  = new_digit;
                        2'd3: work_d[15:12] = new_digit;
                        default: work_d = work_q;
                    endcase
                    carry_d = new_carry;
                    idx_d   = idx_q + 2'd1;
                    if (final_edge) begin
                        state_d = IDLE;
                        // A carry out of the thousands digit pins the score at 9999;
                        // once there, any non-zero add carries out again.
                        disp_d  = new_carry ? 16'h9999 : {new_digit, work_q[11:0]};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            pts_q   <= 4'd0;
            work_q  <= 16'd0;
            disp_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            pts_q   <= pts_d;
            work_q  <= work_d;
            disp_q  <= disp_d;
        end
    end

    assign bus.ready  = (state_q == IDLE);
    assign bus.digit0 = disp_q[3:0];
    assign bus.digit1 = disp_q[7:4];
    assign bus.digit2 = disp_q[11:8];
    assign bus.digit3 = disp_q[15:12];

`ifdef SCORE_LEVEL_EN
    logic [2:0] lines_q, lines_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] level_q, level_d;
    logic [4:0] lsum;

    function automatic logic [2:0] line_count(input logic [2:0] lines);
        return (lines >= 3'd1 && lines <= 3'd4) ? lines : 3'd0;
    endfunction

    always_comb begin
        lines_d = lines_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        lsum    = {1'b0, cnt_q} + {2'b00, lines_q};
        if (bus.score_clr) begin
            lines_d = 3'd0;
            cnt_d   = 4'd0;
            level_d = 4'd0;
        end else if (accept) begin
            lines_d = line_count(bus.clear_lines);
        end else if (final_edge) begin
            if (lsum >= 5'(LINES_PER_LEVEL)) begin
                cnt_d = 4'(lsum - 5'(LINES_PER_LEVEL));
                if (level_q != 4'd9) begin
                    level_d = level_q + 4'd1;
                end
            end else begin
                cnt_d = lsum[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_q <= 3'd0;
            cnt_q   <= 4'd0;
            level_q <= 4'd0;
        end else begin
            lines_q <= lines_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign bus.level = level_q;
`else
    assign bus.level = 4'd0;
`endif

endmodule

// File: tb/tb_score_bcd.sv
// tb/tb_score_bcd.sv - self-checking bench for score_bcd
module tb_score_bcd;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    score_bcd_if bus ();

    score_bcd #(.LINES_PER_LEVEL(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  level;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]  lines;
        logic [15:0] exp_digits;
    } vec_t;
    vec_t vecs[8];

    int model_score;
    int model_lines;
    int model_level;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int pts_of(input int l);
        case (l)
            1: return 1;
            2: return 3;
            3: return 5;
            4: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] disp();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        model_score = 0;
        model_lines = 0;
        model_level = 0;
        sb.delete();
    endtask

    task automatic model_add(input int l);
        exp_t e;
        model_score += pts_of(l);
        if (model_score > 9999) model_score = 9999;
`ifdef SCORE_LEVEL_EN
        if (l >= 1 && l <= 4) model_lines += l;
        if (model_lines >= 10) begin
            model_lines -= 10;
            if (model_level < 9) model_level++;
        end
`endif
        e.digits = to_bcd(model_score);
        e.level  = 4'(model_level);
        sb.push_back(e);
    endtask

    // Issue one request; optionally keep clear_valid high during the add to
    // show that it is ignored rather than queued.
    task automatic do_req(input int l, input bit poke);
        logic [15:0] pre;
        int busy;
        exp_t e;
        @(negedge clk);
        check("ready_before", 32'(bus.ready), 32'd1);
        pre = disp();
        bus.clear_valid = 1'b1;
        bus.clear_lines = 3'(l);
        model_add(l);
        @(negedge clk);
        bus.clear_valid = poke;
        bus.clear_lines = 3'd4;
        busy = 0;
        while (!bus.ready && busy < 20) begin
            busy++;
            check("hold_during_add", 32'(disp()), 32'(pre));
            @(negedge clk);
        end
        bus.clear_valid = 1'b0;
        if (busy >= 20) check("busy_timeout", 32'(busy), 32'd4);
        check("busy_len", 32'(busy), 32'd4);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("score", 32'(disp()), 32'(e.digits));
            check("level", 32'(bus.level), 32'(e.level));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd1, 16'h0009};
        vecs[1] = '{3'd2, 16'h0012};
        vecs[2] = '{3'd3, 16'h0017};
        vecs[3] = '{3'd0, 16'h0017};
        vecs[4] = '{3'd5, 16'h0017};
        vecs[5] = '{3'd7, 16'h0017};
        vecs[6] = '{3'd4, 16'h0025};
        vecs[7] = '{3'd6, 16'h0025};

        rst             = 1'b1;
        bus.score_clr   = 1'b0;
        bus.clear_valid = 1'b0;
        bus.clear_lines = 3'd0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_digits", 32'(disp()), 32'h0);
        check("rst_level", 32'(bus.level), 32'd0);
        rst = 1'b0;

        // Single four-line clear from reset.
        do_req(4, 1'b0);
        check("first_0008", 32'(disp()), 32'h0008);

        // Table of requests including illegal line counts.
        for (int i = 0; i < 8; i++) begin
            do_req(int'(vecs[i].lines), 1'b0);
            check($sformatf("tbl_%0d", i), 32'(disp()), 32'(vecs[i].exp_digits));
        end

        // Clear with a simultaneous request while idle.
        @(negedge clk);
        bus.score_clr   = 1'b1;
        bus.clear_valid = 1'b1;
        bus.clear_lines = 3'd4;
        @(negedge clk);
        bus.score_clr   = 1'b0;
        bus.clear_valid = 1'b0;
        model_clear();
        check("clr_idle_digits", 32'(disp()), 32'h0);
        check("clr_idle_level", 32'(bus.level), 32'd0);
        check("clr_idle_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        check("clr_idle_discard", 32'(bus.ready), 32'd1);

        // Build 0099, then carry across two digits.
        for (int i = 0; i < 12; i++) do_req(4, 1'b0);
        do_req(2, 1'b0);
        check("preload_0099", 32'(disp()), 32'h0099);
        do_req(1, 1'b0);
        check("carry_0100", 32'(disp()), 32'h0100);

        // Requests during ADD are dropped.
        do_req(3, 1'b1);
        check("ignored_0105", 32'(disp()), 32'h0105);

        // Async reset in the middle of an add.
        @(negedge clk);
        bus.clear_valid = 1'b1;
        bus.clear_lines = 3'd4;
        @(negedge clk);
        bus.clear_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_digits", 32'(disp()), 32'h0);
        check("rst_mid_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        model_clear();

        // Three tetrises from zero.
        for (int i = 0; i < 3; i++) do_req(4, 1'b0);
        check("three_tetris_0024", 32'(disp()), 32'h0024);
`ifdef SCORE_LEVEL_EN
        check("three_tetris_level", 32'(bus.level), 32'd1);
`else
        check("three_tetris_level", 32'(bus.level), 32'd0);
`endif

        // Synchronous clear in the middle of an add.
        @(negedge clk);
        bus.clear_valid = 1'b1;
        bus.clear_lines = 3'd4;
        @(negedge clk);
        bus.clear_valid = 1'b0;
        @(negedge clk);
        bus.score_clr = 1'b1;
        @(negedge clk);
        bus.score_clr = 1'b0;
        model_clear();
        check("clr_mid_digits", 32'(disp()), 32'h0);
        check("clr_mid_level", 32'(bus.level), 32'd0);
        check("clr_mid_ready", 32'(bus.ready), 32'd1);
        repeat (5) @(negedge clk);
        check("clr_mid_no_late_write", 32'(disp()), 32'h0);

        // Build 9995, then saturate.
        for (int i = 0; i < 1249; i++) do_req(4, 1'b0);
        do_req(2, 1'b0);
        check("preload_9995", 32'(disp()), 32'h9995);
        do_req(4, 1'b0);
        check("sat_9999", 32'(disp()), 32'h9999);
        do_req(2, 1'b0);
        check("sat_stays_9999", 32'(disp()), 32'h9999);

        repeat (3) @(negedge clk);
        check("idle_hold", 32'(disp()), 32'h9999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
